// File: rtl/picosoc_iomem_fabric_if.sv
// picorv32 native-bus request/response plus the fanned-out peripheral side,
// bundled so the fabric, the CPU wrapper and the peripherals share one definition.
interface picosoc_iomem_fabric_if #(
   parameter int NUM_SLAVES = 8
);
   logic                     m_valid;
   logic                     m_instr;
   logic [31:0]              m_addr;
   logic [31:0]              m_wdata;
   logic [3:0]               m_wstrb;
   logic                     m_ready;
   logic [31:0]              m_rdata;

   logic [NUM_SLAVES-1:0]    s_valid;
   logic [31:0]              s_addr;
   logic [31:0]              s_wdata;
   logic [3:0]               s_wstrb;
   logic [NUM_SLAVES-1:0]    s_ready;
   logic [32*NUM_SLAVES-1:0] s_rdata;

   modport master (
      output m_valid, m_instr, m_addr, m_wdata, m_wstrb,
      input  m_ready, m_rdata
   );

   modport slave (
      input  s_valid, s_addr, s_wdata, s_wstrb,
      output s_ready, s_rdata
   );

   modport fabric (
      input  m_valid, m_instr, m_addr, m_wdata, m_wstrb,
      output m_ready, m_rdata,
      output s_valid, s_addr, s_wdata, s_wstrb,
      input  s_ready, s_rdata
   );
endinterface

// File: rtl/picosoc_iomem_fabric.sv
// Address-decoding fabric from one picorv32 native port to NUM_SLAVES peripherals
// with sticky error capture. Define PICOSOC_IOMEM_TIMEOUT_EN to add an ACCESS timeout.
module picosoc_iomem_fabric #(
   parameter int                      NUM_SLAVES     = 8,
   parameter logic [8*NUM_SLAVES-1:0] REGION_MAP     = 64'h0807_0605_0403_0200,
   parameter int                      TIMEOUT_CYCLES = 1024,
   parameter logic [31:0]             ERR_RDATA      = 32'hFFFF_FFFF
) (
   input  logic                     clk,
   input  logic                     resetn,
   picosoc_iomem_fabric_if.fabric   bus,
   output logic                     err_o,
   output logic [31:0]              err_addr_o,
   input  logic                     err_clr_i
);

   localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t           state;
   logic [IDX_W-1:0] sel;
   logic             hit;
   logic [IDX_W-1:0] hit_idx;
   logic [31:0]      sel_rdata;
   logic             tmo_hit;
   logic             err_set;
   logic [31:0]      err_addr_nxt;
   logic             unused_instr;

   assign unused_instr = bus.m_instr;

   // Scan from the top so the lowest matching slave index is the one kept.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
         if (bus.m_addr[31:24] == REGION_MAP[8*i +: 8]) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      sel_rdata = bus.s_rdata[32*sel +: 32];
   end

`ifdef PICOSOC_IOMEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CNT_W-1:0] tmo_cnt;

   // Held at zero in IDLE so the first ACCESS cycle always counts from zero.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tmo_cnt <= '0;
      end else if (state == ACCESS) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
         tmo_cnt <= '0;
      end
   end

   assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;

   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      err_set      = 1'b0;
      err_addr_nxt = bus.s_addr;
      if (state == IDLE && bus.m_valid && !hit) begin
         err_set      = 1'b1;
         err_addr_nxt = bus.m_addr;
      end else if (state == ACCESS && bus.m_valid && !bus.s_ready[sel] && tmo_hit) begin
         err_set = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         sel         <= '0;
         bus.m_ready <= 1'b0;
         bus.m_rdata <= '0;
         bus.s_valid <= '0;
         bus.s_addr  <= '0;
         bus.s_wdata <= '0;
         bus.s_wstrb <= '0;
      end else begin
         case (state)
            IDLE: begin
               bus.m_ready <= 1'b0;
               bus.s_valid <= '0;
               if (bus.m_valid) begin
                  sel         <= hit_idx;
                  bus.s_addr  <= bus.m_addr;
                  bus.s_wdata <= bus.m_wdata;
                  bus.s_wstrb <= bus.m_wstrb;
                  if (hit) begin
                     bus.s_valid <= NUM_SLAVES'(1) << hit_idx;
                     state       <= ACCESS;
                  end else begin
                     bus.m_rdata <= ERR_RDATA;
                     bus.m_ready <= 1'b1;
                     state       <= RESP;
                  end
               end
            end
            ACCESS: begin
               // A withdrawn request is dropped silently: no response, no error.
               if (!bus.m_valid) begin
                  bus.s_valid <= '0;
                  state       <= IDLE;
               end else if (bus.s_ready[sel]) begin
                  bus.m_rdata <= sel_rdata;
                  bus.m_ready <= 1'b1;
                  bus.s_valid <= '0;
                  state       <= RESP;
               end else if (tmo_hit) begin
                  bus.m_rdata <= ERR_RDATA;
                  bus.m_ready <= 1'b1;
                  bus.s_valid <= '0;
                  state       <= RESP;
               end
            end
            RESP: begin
               bus.m_ready <= 1'b0;
               state       <= IDLE;
            end
            default: begin
               bus.m_ready <= 1'b0;
               bus.s_valid <= '0;
               state       <= IDLE;
            end
         endcase
      end
   end

   // A new error outranks a simultaneous clear; the address only moves when free.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         err_o      <= 1'b0;
         err_addr_o <= '0;
      end else if (err_set) begin
         err_o <= 1'b1;
         if (!err_o || err_clr_i) begin
            err_addr_o <= err_addr_nxt;
         end
      end else if (err_clr_i) begin
         err_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_picosoc_iomem_fabric.sv
// Directed-vector bench for picosoc_iomem_fabric: decode, handshake latency,
// error capture/clear, timeout (or its absence) and mid-access reset.
module tb_picosoc_iomem_fabric;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        err_o;
   logic [31:0] err_addr_o;
   logic        err_clr_i;
   logic        err2_o;
   logic [31:0] err2_addr_o;
   logic        err2_clr_i;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   picosoc_iomem_fabric_if #(.NUM_SLAVES(8)) bus ();
   picosoc_iomem_fabric_if #(.NUM_SLAVES(2)) bus2 ();

   picosoc_iomem_fabric #(
      .NUM_SLAVES     (8),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .bus        (bus),
      .err_o      (err_o),
      .err_addr_o (err_addr_o),
      .err_clr_i  (err_clr_i)
   );

   // Two slaves sharing region 0x05: slave 0 must be chosen.
   picosoc_iomem_fabric #(
      .NUM_SLAVES     (2),
      .REGION_MAP     (16'h0505),
      .TIMEOUT_CYCLES (16)
   ) dut2 (
      .clk        (clk),
      .resetn     (resetn),
      .bus        (bus2),
      .err_o      (err2_o),
      .err_addr_o (err2_addr_o),
      .err_clr_i  (err2_clr_i)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
      bus.m_valid = 1'b1;
      bus.m_instr = 1'b0;
      bus.m_addr  = a;
      bus.m_wdata = wd;
      bus.m_wstrb = ws;
   endtask

   task automatic release_bus();
      bus.m_valid = 1'b0;
      bus.s_ready = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int hits;

      bus.m_valid  = 1'b0;
      bus.m_instr  = 1'b0;
      bus.m_addr   = '0;
      bus.m_wdata  = '0;
      bus.m_wstrb  = '0;
      bus.s_ready  = '0;
      bus.s_rdata  = '0;
      bus2.m_valid = 1'b0;
      bus2.m_instr = 1'b0;
      bus2.m_addr  = '0;
      bus2.m_wdata = '0;
      bus2.m_wstrb = '0;
      bus2.s_ready = '0;
      bus2.s_rdata = {32'h2222_2222, 32'h1111_1111};
      err_clr_i    = 1'b0;
      err2_clr_i   = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_m_ready", 32'(bus.m_ready), 32'd0);
      chk("rst_s_valid", 32'(bus.s_valid), 32'd0);
      chk("rst_m_rdata", bus.m_rdata, 32'd0);
      chk("rst_err_o", 32'(err_o), 32'd0);
      chk("rst_err_addr", err_addr_o, 32'd0);
      chk("rst_s_addr", bus.s_addr, 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      // Read from slave 1, stray ready from slave 0 ignored, ready 3 cycles later
      bus.s_rdata[63:32] = 32'h1234_5678;
      req(32'h0200_0010, 32'h0, 4'h0);
      @(negedge clk);
      chk("rd_s_valid", 32'(bus.s_valid), 32'h02);
      chk("rd_s_addr", bus.s_addr, 32'h0200_0010);
      bus.s_ready = 8'h01;
      @(negedge clk);
      chk("rd_stray_ready", 32'(bus.m_ready), 32'd0);
      chk("rd_s_valid_hold", 32'(bus.s_valid), 32'h02);
      bus.s_ready = 8'h00;
      @(negedge clk);
      @(negedge clk);
      bus.s_ready = 8'h02;
      @(negedge clk);
      chk("rd_m_ready", 32'(bus.m_ready), 32'd1);
      chk("rd_m_rdata", bus.m_rdata, 32'h1234_5678);
      chk("rd_err_o", 32'(err_o), 32'd0);
      chk("rd_s_valid_off", 32'(bus.s_valid), 32'd0);
      release_bus();
      @(negedge clk);
      chk("rd_ready_pulse", 32'(bus.m_ready), 32'd0);
      chk("rd_rdata_hold", bus.m_rdata, 32'h1234_5678);

      // Write to slave 7
      bus.s_rdata[255:224] = 32'h7777_0007;
      req(32'h0800_0004, 32'hA5A5_A5A5, 4'hF);
      @(negedge clk);
      chk("wr_s_valid", 32'(bus.s_valid), 32'h80);
      chk("wr_s_addr", bus.s_addr, 32'h0800_0004);
      chk("wr_s_wdata", bus.s_wdata, 32'hA5A5_A5A5);
      chk("wr_s_wstrb", 32'(bus.s_wstrb), 32'hF);
      bus.s_ready = 8'h80;
      @(negedge clk);
      chk("wr_m_ready", 32'(bus.m_ready), 32'd1);
      chk("wr_m_rdata", bus.m_rdata, 32'h7777_0007);
      release_bus();
      @(negedge clk);
      chk("wr_ready_pulse", 32'(bus.m_ready), 32'd0);

      // Unmapped read
      req(32'h0100_0000, 32'h0, 4'h0);
      @(negedge clk);
      chk("um_s_valid", 32'(bus.s_valid), 32'd0);
      chk("um_m_ready", 32'(bus.m_ready), 32'd1);
      chk("um_m_rdata", bus.m_rdata, 32'hFFFF_FFFF);
      chk("um_err_o", 32'(err_o), 32'd1);
      chk("um_err_addr", err_addr_o, 32'h0100_0000);
      release_bus();
      @(negedge clk);
      chk("um_ready_pulse", 32'(bus.m_ready), 32'd0);

      // Second error while sticky: address must not move
      req(32'h0B00_0000, 32'h0, 4'h0);
      @(negedge clk);
      chk("sticky_err_o", 32'(err_o), 32'd1);
      chk("sticky_err_addr", err_addr_o, 32'h0100_0000);
      release_bus();
      @(negedge clk);

      // Clear coinciding with a new error: new error wins
      req(32'h0900_0000, 32'h0, 4'h0);
      err_clr_i = 1'b1;
      @(negedge clk);
      chk("clr_new_err_o", 32'(err_o), 32'd1);
      chk("clr_new_err_addr", err_addr_o, 32'h0900_0000);
      release_bus();
      @(negedge clk);
      err_clr_i = 1'b0;
      chk("clr_err_o", 32'(err_o), 32'd0);
      chk("clr_err_addr_hold", err_addr_o, 32'h0900_0000);

      // Slave 3 never answers
      req(32'h0400_0000, 32'h0, 4'h0);
      @(negedge clk);
      chk("tmo_s_valid", 32'(bus.s_valid), 32'h08);
`ifdef PICOSOC_IOMEM_TIMEOUT_EN
      n = 0;
      while (bus.m_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_latency", 32'(n), 32'd16);
      chk("tmo_m_rdata", bus.m_rdata, 32'hFFFF_FFFF);
      chk("tmo_err_o", 32'(err_o), 32'd1);
      chk("tmo_err_addr", err_addr_o, 32'h0400_0000);
      release_bus();
      @(negedge clk);
      chk("tmo_ready_pulse", 32'(bus.m_ready), 32'd0);
`else
      hits = 0;
      repeat (10000) begin
         @(negedge clk);
         if (bus.m_ready === 1'b1) hits++;
      end
      chk("notmo_no_ready", 32'(hits), 32'd0);
      chk("notmo_s_valid", 32'(bus.s_valid), 32'h08);
      release_bus();
      @(negedge clk);
      chk("abort_s_valid", 32'(bus.s_valid), 32'd0);
      chk("abort_m_ready", 32'(bus.m_ready), 32'd0);
      chk("abort_err_o", 32'(err_o), 32'd0);
`endif

      // Reset asserted mid-ACCESS
      req(32'h0200_0000, 32'h0, 4'h0);
      @(negedge clk);
      chk("mrst_s_valid_pre", 32'(bus.s_valid), 32'h02);
      resetn = 1'b0;
      #1;
      chk("mrst_s_valid", 32'(bus.s_valid), 32'd0);
      chk("mrst_m_ready", 32'(bus.m_ready), 32'd0);
      bus.m_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("mrst_m_rdata", bus.m_rdata, 32'd0);
      chk("mrst_err_o", 32'(err_o), 32'd0);
      resetn = 1'b1;
      @(negedge clk);
      chk("mrst_idle_s_valid", 32'(bus.s_valid), 32'd0);
      chk("mrst_idle_m_ready", 32'(bus.m_ready), 32'd0);
      bus.s_rdata[95:64] = 32'hCAFE_0002;
      req(32'h0300_0020, 32'h0, 4'h0);
      @(negedge clk);
      chk("post_s_valid", 32'(bus.s_valid), 32'h04);
      bus.s_ready = 8'h04;
      @(negedge clk);
      chk("post_m_ready", 32'(bus.m_ready), 32'd1);
      chk("post_m_rdata", bus.m_rdata, 32'hCAFE_0002);
      release_bus();
      @(negedge clk);
      chk("post_ready_pulse", 32'(bus.m_ready), 32'd0);

      // Duplicate region: lowest index wins
      bus2.m_valid = 1'b1;
      bus2.m_addr  = 32'h0500_0000;
      @(negedge clk);
      chk("dup_s_valid", 32'(bus2.s_valid), 32'h1);
      bus2.s_ready = 2'b11;
      @(negedge clk);
      chk("dup_m_ready", 32'(bus2.m_ready), 32'd1);
      chk("dup_m_rdata", bus2.m_rdata, 32'h1111_1111);
      bus2.m_valid = 1'b0;
      bus2.s_ready = 2'b00;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
